piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per parallel word (legal range 2..32).
REQ-002 SHALL have parameter DIV, default 1: clock cycles per serial bit (legal range 1..16).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load_data  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port load_valid  input  1  load_data is valid this cycle.
REQ-008 SHALL have port load_ready  output  1  block accepts load_data this cycle.
REQ-009 SHALL have port sout  output  1  serial bit stream (the din of the downstream sequence detector).
REQ-010 SHALL have port sout_valid  output  1  one-cycle strobe on the first cycle of each bit period.
REQ-011 SHALL have port busy  output  1  high while a word is being shifted.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last bit period of a word.

Function
REQ-013 SHALL implement states IDLE and SHIFT; reset enters IDLE.
REQ-014 SHALL accept a word only at an edge where load_valid and load_ready are both 1 (the "load edge").
REQ-015 SHALL drive load_ready combinationally: 1 in IDLE; 1 in SHIFT only on the final cycle of the final bit (bit_cnt = WIDTH-1 and div_cnt = DIV-1); 0 otherwise.
REQ-016 SHALL ignore load_valid while load_ready is 0, leaving shift data and counters unchanged.
REQ-017 SHALL, on a load edge, capture load_data into a shift register, clear bit_cnt and div_cnt, and enter or remain in SHIFT.
REQ-018 SHALL present the first bit on sout in the cycle after the load edge (latency 1), with sout_valid = 1 in that cycle.
REQ-019 SHALL hold each bit on sout for exactly DIV cycles; sout_valid is 1 only on the first of those cycles (continuously 1 when DIV = 1).
REQ-020 SHALL wrap div_cnt from DIV-1 to 0 and then advance to the next bit; when bit_cnt = WIDTH-1 wraps, the word is complete.
REQ-021 SHALL, on word completion without a simultaneous load edge, return to IDLE, with sout = 0, sout_valid = 0 and busy = 0 in the next cycle.
REQ-022 SHALL, on word completion with a simultaneous load edge, start the new word with no gap cycle, so serial output stays continuous across words.
REQ-023 SHALL assert done for exactly one cycle, in the cycle after every word completion, including back-to-back completions.
REQ-024 SHALL drive busy = 1 exactly when the state is SHIFT.
REQ-025 SHALL register sout, sout_valid and done, so no output glitches on load_data.

Reset
REQ-026 SHALL, at any edge where reset = 1, force state IDLE, counters 0, shift register 0, sout 0, sout_valid 0, busy 0 and done 0, regardless of load_valid.
REQ-027 SHALL, when reset is asserted mid-word, discard the word and produce no done pulse for it.
REQ-028 SHALL hold load_ready = 0 while reset = 1, and return it to 1 at the first cycle after reset deasserts.

Structure
REQ-029 SHALL take the state encoding (IDLE = 1'b0, SHIFT = 1'b1) and the default WIDTH from shared package serial_pkg, which is also used by the sequence detectors.
REQ-030 SHALL size counters as $clog2(WIDTH) and max(1, $clog2(DIV)) bits.
REQ-031 SHALL place the DIV cycle counter in a single sub-module bit_period_counter (inputs clear and enable; outputs count and wrap).

Verification
REQ-032 SHALL verify: WIDTH=8, DIV=1, MSB_FIRST=1, load 8'hB0 at cycle 0 -> sout 1,0,1,1,0,0,0,0 on cycles 1-8, done=1 at cycle 9, busy=0 at cycle 9.
REQ-033 SHALL verify: load_valid held high with 8'hB0 then 8'h0B -> 16 consecutive sout_valid cycles, sout 10110000 00001011, done at cycles 9 and 17, and the downstream detector flags two matches.
REQ-034 SHALL verify: DIV=3, load 8'hA5 -> each bit held 3 cycles, sout_valid on cycles 1,4,...,22, done at cycle 25.
REQ-035 SHALL verify: MSB_FIRST=0, load 8'h0D -> sout 1,0,1,1,0,0,0,0.
REQ-036 SHALL verify: reset at cycle 4 of the 8'hB0 word -> sout=0, busy=0 next cycle, no done pulse, load_ready=1 after reset deasserts.
REQ-037 SHALL verify: load_valid pulsed with 8'hFF at cycle 3 during a shift -> word not accepted, output stream unchanged.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: FSM encoding, default word width,
// and a counter-width helper used by the serializer and detectors.
package serial_pkg;

    localparam int SERIAL_WIDTH = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Counts clock cycles within one serial bit period; wrap marks
// the final cycle of the period while enabled.
module bit_period_counter
    import serial_pkg::*;
#(
    parameter int DIV = 1,
    parameter int CW  = cnt_bits(DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          wrap
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign wrap  = enable && (count_q == CW'(DIV - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load, per-bit clock
// division and seamless back-to-back words.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = SERIAL_WIDTH,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = cnt_bits(WIDTH);
    localparam int DW = cnt_bits(DIV);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_nx;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sv_q, sv_d;
    logic             done_q, done_d;
    logic [DW-1:0]    div_cnt;
    logic             div_wrap;
    logic             in_shift;
    logic             last_bit;
    logic             word_end;
    logic             load;

    assign in_shift   = (state_q == ST_SHIFT);
    assign last_bit   = (bit_cnt_q == BW'(WIDTH - 1));
    assign word_end   = in_shift && last_bit && (div_cnt == DW'(DIV - 1));
    assign load_ready = !reset && (!in_shift || word_end);
    assign load       = load_valid && load_ready;

    assign shift_nx = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_q[WIDTH-1:1]};

    bit_period_counter #(
        .DIV (DIV),
        .CW  (DW)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (in_shift),
        .count  (div_cnt),
        .wrap   (div_wrap)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sv_d      = 1'b0;
        done_d    = word_end;
        if (load) begin
            state_d   = ST_SHIFT;
            shift_d   = load_data;
            bit_cnt_d = '0;
            sv_d      = 1'b1;
        end else if (word_end) begin
            state_d   = ST_IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (div_wrap) begin
            shift_d   = shift_nx;
            bit_cnt_d = bit_cnt_q + 1'b1;
            sv_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sv_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sv_q      <= sv_d;
            done_q    <= done_d;
        end
    end

    // The current bit always sits at the output end of the shift register.
    assign sout       = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign sout_valid = sv_q;
    assign busy       = in_shift;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first DIV=1, DIV=3 and
// LSB-first instances driven with directed words.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic       v0, v1, v2;
    logic [7:0] d0, d1, d2;
    logic       rdy0, so0, sv0, busy0, done0;
    logic       rdy1, so1, sv1, busy1, done1;
    logic       rdy2, so2, sv2, busy2, done2;

    int n_chk  = 0;
    int n_fail = 0;
    int hits   = 0;
    int base;
    logic [3:0] det_sr = 4'b0000;
    logic [7:0] dat;

    bit exp_q0[$];
    bit exp_q1[$];
    bit exp_q2[$];

    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_ser0 (
        .clk(clk), .reset(rst0), .load_data(d0), .load_valid(v0),
        .load_ready(rdy0), .sout(so0), .sout_valid(sv0),
        .busy(busy0), .done(done0)
    );

    piso_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1)) u_ser1 (
        .clk(clk), .reset(rst1), .load_data(d1), .load_valid(v1),
        .load_ready(rdy1), .sout(so1), .sout_valid(sv1),
        .busy(busy1), .done(done1)
    );

    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_ser2 (
        .clk(clk), .reset(rst1), .load_data(d2), .load_valid(v2),
        .load_ready(rdy2), .sout(so2), .sout_valid(sv2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input int which, input logic [7:0] d,
                             input bit msb);
        bit b;
        for (int i = 0; i < 8; i++) begin
            b = msb ? d[7-i] : d[i];
            case (which)
                0:       exp_q0.push_back(b);
                1:       exp_q1.push_back(b);
                default: exp_q2.push_back(b);
            endcase
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitors plus a 1011 detector model on stream 0.
    always @(negedge clk) begin
        if (sv0) begin
            if (exp_q0.size() == 0) chk("sb0_size", 0, 1);
            else chk("sout0", so0, exp_q0.pop_front());
            det_sr = {det_sr[2:0], so0};
            if (det_sr == 4'b1011) hits++;
        end
        if (sv1) begin
            if (exp_q1.size() == 0) chk("sb1_size", 0, 1);
            else chk("sout1", so1, exp_q1.pop_front());
        end
        if (sv2) begin
            if (exp_q2.size() == 0) chk("sb2_size", 0, 1);
            else chk("sout2", so2, exp_q2.pop_front());
        end
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        step(2);
        chk("rst_sout", so0, 0);
        chk("rst_sv", sv0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_rdy", rdy0, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        #1 chk("rdy_after_rst", rdy0, 1);

        // Single word, MSB first
        v0 = 1'b1; d0 = 8'hB0; push_word(0, 8'hB0, 1'b1);
        step(1);
        v0 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("w1_busy", busy0, 1);
            chk("w1_done", done0, 0);
            chk("w1_sv", sv0, 1);
            step(1);
        end
        chk("w1_done9", done0, 1);
        chk("w1_busy9", busy0, 0);
        chk("w1_sout9", so0, 0);
        chk("w1_sv9", sv0, 0);
        step(1);
        chk("w1_done10", done0, 0);

        // Back-to-back words with load_valid held high
        base = hits;
        v0 = 1'b1; d0 = 8'hB0; push_word(0, 8'hB0, 1'b1);
        step(1);
        d0 = 8'h0B; push_word(0, 8'h0B, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            if (k == 9) v0 = 1'b0;
            chk("b2b_sv", sv0, 1);
            chk("b2b_done", done0, (k == 9));
            if (k <= 8) chk("b2b_rdy", rdy0, (k == 8));
            step(1);
        end
        chk("b2b_done17", done0, 1);
        chk("b2b_busy17", busy0, 0);
        chk("b2b_sv17", sv0, 0);
        chk("b2b_hits", hits - base, 2);
        step(1);

        // Load attempt mid-word is ignored
        v0 = 1'b1; d0 = 8'hB0; push_word(0, 8'hB0, 1'b1);
        step(1);
        v0 = 1'b0;
        step(2);
        v0 = 1'b1; d0 = 8'hFF;
        #1 chk("ign_rdy", rdy0, 0);
        step(1);
        v0 = 1'b0;
        step(5);
        chk("ign_done", done0, 1);
        chk("ign_busy", busy0, 0);
        chk("ign_sb", exp_q0.size(), 0);
        step(1);
        chk("ign_idle", busy0, 0);

        // Reset in the middle of a word
        v0 = 1'b1; d0 = 8'hB0; push_word(0, 8'hB0, 1'b1);
        step(1);
        v0 = 1'b0;
        step(3);
        rst0 = 1'b1; v0 = 1'b1; d0 = 8'hFF;
        #1 chk("mid_rst_rdy", rdy0, 0);
        step(1);
        v0 = 1'b0;
        chk("mid_sout", so0, 0);
        chk("mid_busy", busy0, 0);
        chk("mid_sv", sv0, 0);
        chk("mid_done", done0, 0);
        chk("mid_sb", exp_q0.size(), 4);
        exp_q0.delete();
        rst0 = 1'b0;
        #1 chk("mid_rdy_after", rdy0, 1);
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("mid_nodone", done0, 0);
            chk("mid_idle", busy0, 0);
        end

        // DIV=3 instance
        v1 = 1'b1; d1 = 8'hA5; push_word(1, 8'hA5, 1'b1);
        dat = 8'hA5;
        step(1);
        v1 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            chk("div_sv", sv1, ((k - 1) % 3 == 0));
            chk("div_sout", so1, dat[7 - (k - 1) / 3]);
            chk("div_busy", busy1, 1);
            if (k == 24) chk("div_done24", done1, 0);
            step(1);
        end
        chk("div_done25", done1, 1);
        chk("div_busy25", busy1, 0);

        // LSB-first instance
        v2 = 1'b1; d2 = 8'h0D; push_word(2, 8'h0D, 1'b0);
        step(1);
        v2 = 1'b0;
        step(8);
        chk("lsb_done", done2, 1);
        chk("lsb_busy", busy2, 0);
        step(1);

        chk("sb0_end", exp_q0.size(), 0);
        chk("sb1_end", exp_q1.size(), 0);
        chk("sb2_end", exp_q2.size(), 0);
        chk("rdy1_end", rdy1, 1);
        chk("rdy2_end", rdy2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
